// File: rtl/if_stage_pq.sv
// Fetch stage with a variable-latency imem handshake, a DEPTH-entry prefetch queue and the IF/ID register.
// Optional macro IF_QUEUE_BYPASS_EN lets a fetch land directly in IF/ID when the queue is empty.
module if_stage_pq #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [1:0]        pcsource,
  input  logic [ADDR_W-1:0] bpc,
  input  logic [ADDR_W-1:0] rpc,
  input  logic [ADDR_W-1:0] jpc,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [ADDR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] inst,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] pc4,
  output logic              inst_valid
);

  localparam int                PW   = $clog2(DEPTH);
  localparam int                CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]     FULL = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_q_addr [DEPTH];
  logic [ADDR_W-1:0] r_q_inst [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [ADDR_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pc4;
  logic              r_valid;

  logic              w_redirect;
  logic              w_xfer;
  logic              w_bypass;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_target;

  // Request is withheld on redirect so an ack in that cycle never completes a transfer.
  assign w_redirect = (pcsource != 2'd0);
  assign imem_req   = (r_count < FULL) && !clr && !w_redirect;
  assign imem_addr  = r_fetch_pc;
  assign w_xfer     = imem_req && imem_ack;

`ifdef IF_QUEUE_BYPASS_EN
  assign w_bypass = w_xfer && (r_count == '0) && !stall;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_xfer && !w_bypass;
  assign w_pop  = !w_redirect && !stall && (r_count != '0);

  always_comb begin
    w_target = jpc;
    case (pcsource)
      2'd1:    w_target = bpc;
      2'd2:    w_target = rpc;
      default: w_target = jpc;
    endcase
  end

  // Queue storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_wr_ptr] <= r_fetch_pc;
      r_q_inst[r_wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_fetch_pc <= RESET_PC;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else if (w_redirect) begin
      r_fetch_pc <= w_target;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_xfer) r_fetch_pc <= r_fetch_pc + FOUR;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // IF/ID register: redirect bubble beats stall, stall beats pop.
  always_ff @(posedge clk) begin
    if (clr || w_redirect) begin
      r_inst  <= '0;
      r_pc    <= '0;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (stall) begin
      r_inst  <= r_inst;
      r_pc    <= r_pc;
      r_pc4   <= r_pc4;
      r_valid <= r_valid;
    end else if (w_pop) begin
      r_inst  <= r_q_inst[r_rd_ptr];
      r_pc    <= r_q_addr[r_rd_ptr];
      r_pc4   <= r_q_addr[r_rd_ptr] + FOUR;
      r_valid <= 1'b1;
    end else if (w_bypass) begin
      r_inst  <= imem_rdata;
      r_pc    <= r_fetch_pc;
      r_pc4   <= r_fetch_pc + FOUR;
      r_valid <= 1'b1;
    end else begin
      r_inst  <= '0;
      r_pc    <= '0;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end
  end

  assign inst       = r_inst;
  assign PC         = r_pc;
  assign pc4        = r_pc4;
  assign inst_valid = r_valid;

endmodule

// File: tb/tb_if_stage_pq.sv
// Bench for if_stage_pq: directed phases plus random traffic, checked against a queue-based fetch model.
module tb_if_stage_pq;

  localparam int          ADDR_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  // Clock / reset signals
  logic              clk = 1'b0;
  logic              clr;
  logic [1:0]        pcsource;
  logic [ADDR_W-1:0] bpc, rpc, jpc;
  logic              stall;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [ADDR_W-1:0] imem_rdata;
  logic [ADDR_W-1:0] inst, PC, pc4;
  logic              inst_valid;

  always #5 clk = ~clk;

  // Memory returns addr + 0x100 for every fetch.
  assign imem_rdata = imem_addr + 32'h100;

  if_stage_pq #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .clr(clr), .pcsource(pcsource), .bpc(bpc), .rpc(rpc), .jpc(jpc),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst(inst), .PC(PC), .pc4(pc4), .inst_valid(inst_valid)
  );

  // Reference model: fetch pointer, FIFO of fetched words, IF/ID contents.
  logic [31:0] mq_addr[$];
  logic [31:0] mq_inst[$];
  logic [31:0] m_fpc;
  logic [31:0] m_inst, m_pc, m_pc4;
  logic        m_valid;
  logic        m_last_req;

  int vectors = 0;
  int errors  = 0;
  int wait_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_bubble();
    m_inst = '0; m_pc = '0; m_pc4 = '0; m_valid = 1'b0;
  endtask

  // One clock cycle: drive, check request side, clock, update model, check IF/ID side.
  task automatic step(input logic c, input logic [1:0] pcs, input logic st, input logic ak);
    logic        req, xfer, consumed;
    logic [31:0] word;
    clr = c; pcsource = pcs; stall = st; imem_ack = ak;
    #1;
    req = (mq_addr.size() < DEPTH) && !c && (pcs == 2'd0);
    chk("imem_req", imem_req, req);
    chk("imem_addr", imem_addr, m_fpc);
    m_last_req = req;
    @(posedge clk);
    if (c) begin
      m_fpc = RESET_PC;
      mq_addr.delete(); mq_inst.delete();
      model_bubble();
    end else if (pcs != 2'd0) begin
      model_bubble();
      mq_addr.delete(); mq_inst.delete();
      m_fpc = (pcs == 2'd1) ? bpc : (pcs == 2'd2) ? rpc : jpc;
    end else begin
      xfer     = req && ak;
      word     = m_fpc + 32'h100;
      consumed = 1'b0;
      if (!st) begin
        if (mq_addr.size() > 0) begin
          m_pc    = mq_addr.pop_front();
          m_inst  = mq_inst.pop_front();
          m_pc4   = m_pc + 32'd4;
          m_valid = 1'b1;
        end
`ifdef IF_QUEUE_BYPASS_EN
        else if (xfer) begin
          m_pc = m_fpc; m_inst = word; m_pc4 = m_fpc + 32'd4; m_valid = 1'b1;
          consumed = 1'b1;
        end
`endif
        else model_bubble();
      end
      if (xfer && !consumed) begin
        mq_addr.push_back(m_fpc);
        mq_inst.push_back(word);
      end
      if (xfer) m_fpc = m_fpc + 32'd4;
    end
    #1;
    chk("inst", inst, m_inst);
    chk("PC", PC, m_pc);
    chk("pc4", pc4, m_pc4);
    chk("inst_valid", inst_valid, m_valid);
  endtask

  // Scoreboard-style explicit queue of PCs expected to appear during the streaming phase.
  logic [31:0] exp_q[$];

  initial begin
    clr = 1'b1; pcsource = 2'd0; stall = 1'b0; imem_ack = 1'b0;
    bpc = 32'h40; rpc = 32'h80; jpc = 32'hC0;
    @(posedge clk); #1;
    m_fpc = RESET_PC; model_bubble(); m_last_req = 1'b0;

    // Reset held for two cycles, outputs must be zero.
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);

    // Streaming with ack tied high: PCs 0,4,8,12,... in order.
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1);
      if (inst_valid && exp_q.size() > 0) begin
        chk("stream_pc", PC, exp_q[0]);
        chk("stream_inst", inst, exp_q[0] + 32'h100);
        void'(exp_q.pop_front());
      end
    end
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Stall long enough to fill the queue, then release.
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1);
    chk("full_req_low", imem_req, 1'b0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // Redirect via each target with entries queued.
    for (int s = 1; s <= 3; s++) begin
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      step(0, 2'(s), 0, 1);
      chk("redir_bubble", inst_valid, 1'b0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    end

    // Slow memory: ack three cycles after request rises.
    wait_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      step(0, 0, 0, (wait_cnt >= 3));
      if (m_last_req && wait_cnt >= 3) wait_cnt = 0;
      else if (m_last_req) wait_cnt++;
      else wait_cnt = 0;
    end

    // Redirect racing an ack.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    jpc = 32'h200;
    step(0, 3, 0, 1);
    chk("race_fpc", imem_addr, 32'h200);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // Random traffic including occasional reset and redirects.
    for (int i = 0; i < 400; i++) begin
      bpc = $urandom(); rpc = $urandom(); jpc = $urandom();
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
           ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 9) < 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
